// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, note codes,
// ROM entry layout and the built-in 16-step tune.
package note_seq_pkg;

  localparam int unsigned ROM_DEPTH = 16;
  localparam int unsigned STEP_W    = 4;
  localparam int unsigned NOTE_W    = 3;
  localparam int unsigned KEY_N     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LIVE,
    ST_NOTE,
    ST_GAP
  } state_e;

  localparam logic [NOTE_W-1:0] NOTE_DO4  = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_RE4  = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_MI4  = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_FA4  = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_SOL4 = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_LA4  = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_SI4  = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_DO5  = 3'd7;

  // A note lasts (beats+1) beats.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [1:0]        beats;
  } rom_entry_t;

  // Listed from step 15 down to step 0.
  localparam rom_entry_t [ROM_DEPTH-1:0] DEFAULT_SONG = {
    {NOTE_DO4, 2'd3}, {NOTE_RE4, 2'd1}, {NOTE_RE4, 2'd0}, {NOTE_MI4, 2'd1},
    {NOTE_MI4, 2'd0}, {NOTE_RE4, 2'd0}, {NOTE_DO4, 2'd0}, {NOTE_DO4, 2'd0},
    {NOTE_RE4, 2'd0}, {NOTE_MI4, 2'd0}, {NOTE_FA4, 2'd0}, {NOTE_SOL4, 2'd0},
    {NOTE_SOL4, 2'd0}, {NOTE_FA4, 2'd0}, {NOTE_MI4, 2'd0}, {NOTE_MI4, 2'd0}
  };

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Combinational 16x5 tune lookup.
module song_rom
  import note_seq_pkg::*;
#(
  parameter rom_entry_t [ROM_DEPTH-1:0] SONG = DEFAULT_SONG
) (
  input  logic [STEP_W-1:0] addr_i,
  output rom_entry_t        entry_c_o
);

  assign entry_c_o = SONG[addr_i];

endmodule

// File: rtl/note_sequencer.sv
// Live-key / tune-player arbiter driving the tone divider note select and gate.
// Define NOTE_SEQ_DEBOUNCE_EN to add a per-key debouncer after the synchronizer.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned BEAT_DIV   = 12_500_000,
  parameter int unsigned GAP_DIV    = 1_250_000,
  parameter int unsigned SONG_LEN   = 16,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter rom_entry_t [ROM_DEPTH-1:0] SONG = DEFAULT_SONG
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [KEY_N-1:0]  keys,
  input  logic              play,
  input  logic              stop,
  output logic [NOTE_W-1:0] scaler,
  output logic              tone_en,
  output logic              busy,
  output logic [STEP_W-1:0] step
);

  localparam int unsigned NOTE_CW = $clog2(4 * BEAT_DIV);
  localparam int unsigned GAP_CW  = $clog2(GAP_DIV);
  localparam int unsigned CNT_RAW = (NOTE_CW > GAP_CW) ? NOTE_CW : GAP_CW;
  localparam int unsigned CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;

  if (SONG_LEN < 1 || SONG_LEN > ROM_DEPTH || DEB_CYCLES < 1 ||
      BEAT_DIV < 1 || GAP_DIV < 1) begin : g_bad_cfg
    $error("note_sequencer: parameter out of range");
  end

  logic [KEY_N-1:0]  sync1_q, sync2_q, key_cond_c;
  logic [NOTE_W-1:0] key_idx_c;
  logic              key_any_c, play_q, play_edge_c;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      play_q  <= 1'b0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      play_q  <= play;
    end
  end

`ifdef NOTE_SEQ_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [KEY_N-1:0]            deb_q, deb_d;
  logic [KEY_N-1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Output follows the synchronized bit only after DEB_CYCLES matching samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < int'(KEY_N); i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      deb_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign key_cond_c = deb_q;
`else
  assign key_cond_c = sync2_q;
`endif

  assign key_any_c   = |key_cond_c;
  assign play_edge_c = play & ~play_q;

  // Lowest pressed key wins.
  always_comb begin
    key_idx_c = '0;
    for (int i = int'(KEY_N) - 1; i >= 0; i--) begin
      if (key_cond_c[i]) key_idx_c = NOTE_W'(i);
    end
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, note_len_c;
  logic [STEP_W-1:0] step_q, step_d, rom_addr_c;
  logic [NOTE_W-1:0] scaler_q, scaler_d;
  logic              tone_en_q, tone_en_d, busy_q, busy_d, last_step_c;
  rom_entry_t        rom_c;

  // The ROM is only consulted when entering NOTE: step 0 from IDLE, step+1 from GAP.
  assign rom_addr_c  = (state_q == ST_GAP) ? step_q + STEP_W'(1) : '0;
  assign note_len_c  = CNT_W'((32'(rom_c.beats) + 32'd1) * BEAT_DIV - 32'd1);
  assign last_step_c = (step_q == STEP_W'(SONG_LEN - 1));

  song_rom #(.SONG(SONG)) u_rom (
    .addr_i    (rom_addr_c),
    .entry_c_o (rom_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    scaler_d = scaler_q;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (key_any_c) begin
          state_d  = ST_LIVE;
          scaler_d = key_idx_c;
        end else if (play_edge_c) begin
          state_d  = ST_NOTE;
          step_d   = '0;
          cnt_d    = note_len_c;
          scaler_d = rom_c.note;
        end
      end
      ST_LIVE: begin
        if (!key_any_c) state_d = ST_IDLE;
        else            scaler_d = key_idx_c;
      end
      ST_NOTE, ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (key_any_c) begin
          state_d  = ST_LIVE;
          step_d   = '0;
          scaler_d = key_idx_c;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ST_NOTE) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_DIV - 1);
        end else if (last_step_c) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else begin
          state_d  = ST_NOTE;
          step_d   = step_q + STEP_W'(1);
          cnt_d    = note_len_c;
          scaler_d = rom_c.note;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tone_en_d = (state_d == ST_LIVE) || (state_d == ST_NOTE);
    busy_d    = (state_d == ST_NOTE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      scaler_q  <= '0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      scaler_q  <= scaler_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
    end
  end

  assign scaler  = scaler_q;
  assign tone_en = tone_en_q;
  assign busy    = busy_q;
  assign step    = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: per-cycle expected outputs are queued
// with the stimulus and popped one per clock.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int unsigned BEAT_DIV   = 4;
  localparam int unsigned GAP_DIV    = 2;
  localparam int unsigned SONG_LEN   = 3;
  localparam int unsigned DEB_CYCLES = 3;
`ifdef NOTE_SEQ_DEBOUNCE_EN
  localparam int KEY_LAT = 3 + DEB_CYCLES;
`else
  localparam int KEY_LAT = 3;
`endif
  localparam rom_entry_t [ROM_DEPTH-1:0] TB_SONG =
    {65'd0, NOTE_SOL4, 2'd0, NOTE_MI4, 2'd1, NOTE_DO4, 2'd0};

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys = '0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] scaler;
  logic       tone_en, busy;
  logic [3:0] step;

  typedef struct {
    logic       tone;
    logic [2:0] sc;
    logic       chk_sc;
    logic [3:0] st;
    logic       bsy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  note_sequencer #(
    .BEAT_DIV(BEAT_DIV), .GAP_DIV(GAP_DIV), .SONG_LEN(SONG_LEN),
    .DEB_CYCLES(DEB_CYCLES), .SONG(TB_SONG)
  ) dut (
    .clk_in(clk_in), .rst(rst), .keys(keys), .play(play), .stop(stop),
    .scaler(scaler), .tone_en(tone_en), .busy(busy), .step(step)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t mk(logic tone, logic [2:0] sc, logic chk, logic [3:0] st, logic b);
    exp_t e;
    e.tone = tone; e.sc = sc; e.chk_sc = chk; e.st = st; e.bsy = b;
    return e;
  endfunction

  // Expected outputs t cycles after the play edge (t=1 is the first NOTE cycle).
  function automatic exp_t play_exp(int t);
    int r;
    int dur;
    r = t;
    for (int s = 0; s < int'(SONG_LEN); s++) begin
      dur = (int'(TB_SONG[s].beats) + 1) * int'(BEAT_DIV);
      if (r <= dur) return mk(1'b1, TB_SONG[s].note, 1'b1, 4'(s), 1'b1);
      r -= dur;
      if (r <= int'(GAP_DIV)) return mk(1'b0, 3'd0, 1'b0, 4'(s), 1'b1);
      r -= int'(GAP_DIV);
    end
    return mk(1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
  endfunction

  function automatic exp_t idle_exp();
    return mk(1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
  endfunction

  task automatic push(exp_t e, int n);
    repeat (n) sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) tick();
    n_cmp++;
    if ({scaler, tone_en, busy, step} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_init: scaler=%0d tone_en=%b busy=%b step=%0d, required all 0", scaler, tone_en, busy, step);
    end
    rst = 1'b0;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({scaler, tone_en, busy, step} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_mid_play: scaler=%0d tone_en=%b busy=%b step=%0d, required all 0", scaler, tone_en, busy, step);
    end
    rst = 1'b0;
    push(mk(1'b0, 3'd0, 1'b1, 4'd0, 1'b0), 5);
    for (int t = 1; t <= 5; t++) begin
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL reset_hold t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

  task automatic test_play();
    exp_t e;
    for (int t = 1; t <= 24; t++) push(play_exp(t), 1);
    play = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (t == 1) play = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL play t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

  task automatic test_live();
    exp_t e;
    int   h;
    int   n;
    h = KEY_LAT + 3;
    n = h + KEY_LAT + 1;
    push(idle_exp(), KEY_LAT - 1);
    push(mk(1'b1, 3'd2, 1'b1, 4'd0, 1'b0), 4 + KEY_LAT - 1);
    push(mk(1'b0, 3'd2, 1'b1, 4'd0, 1'b0), 2);
    keys = 8'b0010_0100;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == h) keys = 8'h00;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL live t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

  task automatic test_key_preempt();
    exp_t e;
    int   l;
    int   r;
    int   n;
    l = 7 + KEY_LAT;
    r = l + 2;
    n = r + KEY_LAT + 1;
    for (int t = 1; t < l; t++) push(play_exp(t), 1);
    push(mk(1'b1, 3'd7, 1'b1, 4'd0, 1'b0), 3 + KEY_LAT - 1);
    push(mk(1'b0, 3'd7, 1'b1, 4'd0, 1'b0), 2);
    play = 1'b1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == 1) play = 1'b0;
      if (t == 7) keys = 8'h80;
      if (t == l) play = 1'b1;
      if (t == l + 1) play = 1'b0;
      if (t == r) keys = 8'h00;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL key_preempt t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

  task automatic test_stop_and_key();
    exp_t e;
    int   s;
    int   n;
    s = KEY_LAT + 1;
    n = s + 3 + KEY_LAT + 1;
    for (int t = 1; t < s; t++) push(play_exp(t), 1);
    push(idle_exp(), 1);
    push(mk(1'b1, 3'd3, 1'b1, 4'd0, 1'b0), 3 + KEY_LAT - 1);
    push(mk(1'b0, 3'd3, 1'b1, 4'd0, 1'b0), 2);
    play = 1'b1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == 1) begin play = 1'b0; keys = 8'h08; end
      if (t == s - 1) stop = 1'b1;
      if (t == s) stop = 1'b0;
      if (t == s + 3) keys = 8'h00;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL stop_and_key t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int t = 1; t <= 23; t++) push(play_exp(t), 1);
    for (int t = 24; t <= 27; t++) push(play_exp(t - 23), 1);
    push(idle_exp(), 2);
    play = 1'b1;
    for (int t = 1; t <= 29; t++) begin
      tick();
      if (t == 1 || t == 9 || t == 24) play = 1'b0;
      if (t == 8 || t == 23) play = 1'b1;
      if (t == 27) stop = 1'b1;
      if (t == 28) stop = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL back_to_back t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask

`ifdef NOTE_SEQ_DEBOUNCE_EN
  task automatic test_debounce();
    exp_t e;
    push(idle_exp(), 15);
    push(mk(1'b1, 3'd1, 1'b1, 4'd0, 1'b0), 4);
    push(mk(1'b0, 3'd1, 1'b1, 4'd0, 1'b0), 2);
    keys = 8'h02;
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t == 2 || t == 14) keys = 8'h00;
      if (t == 10) keys = 8'h02;
      e = sb.pop_front();
      n_cmp++;
      if (tone_en !== e.tone || busy !== e.bsy || step !== e.st || (e.chk_sc && scaler !== e.sc)) begin
        n_bad++;
        $display("FAIL debounce t=%0d: tone_en=%b scaler=%0d step=%0d busy=%b, required %b/%0d/%0d/%b",
                 t, tone_en, scaler, step, busy, e.tone, e.sc, e.st, e.bsy);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_play();
    test_live();
    test_key_preempt();
    test_stop_and_key();
    test_back_to_back();
`ifdef NOTE_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
